// File: rtl/target_round_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : target_round_ctrl_if
// Desc     : Player-side inputs and display/lamp outputs of the target round
//            controller, bundled for connection between game logic and board.
// Revision : 1.0
// ============================================================================
interface target_round_ctrl_if #(
    parameter int NUM_TARGETS = 10
);
    logic                   start;
    logic [3:0]             rand_num;
    logic [NUM_TARGETS-1:0] photo_array;
    logic [3:0]             target_idx;
    logic                   target_on;
    logic [31:0]            score;
    logic [7:0]             round_cnt;
    logic                   hit_pulse;
    logic                   miss_pulse;
    logic                   game_over;

    modport master (
        output start, rand_num, photo_array,
        input  target_idx, target_on, score, round_cnt,
        input  hit_pulse, miss_pulse, game_over
    );

    modport slave (
        input  start, rand_num, photo_array,
        output target_idx, target_on, score, round_cnt,
        output hit_pulse, miss_pulse, game_over
    );
endinterface
`default_nettype wire

// File: rtl/target_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : target_round_ctrl
// Desc     : Photo-target game sequencer: picks a lamp per round, times the
//            player's shot, and keeps score and round count.
// Revision : 1.0
// ============================================================================
module target_round_ctrl #(
    parameter int NUM_TARGETS    = 10,
    parameter int ROUNDS         = 20,
    parameter int TIMEOUT_CYCLES = 50000000,
    parameter int GAP_CYCLES     = 25000000
) (
    input  wire logic          clock,
    input  wire logic          reset,
    target_round_ctrl_if.slave bus
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SELECT = 3'd1;
    localparam logic [2:0] S_ARMED  = 3'd2;
    localparam logic [2:0] S_HIT    = 3'd3;
    localparam logic [2:0] S_MISS   = 3'd4;
    localparam logic [2:0] S_GAP    = 3'd5;
    localparam logic [2:0] S_OVER   = 3'd6;

    localparam logic [3:0]  c_num_targets  = 4'(NUM_TARGETS);
    localparam logic [3:0]  c_no_prev      = 4'hF;
    localparam logic [31:0] c_timeout_load = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] c_gap_load     = 32'(GAP_CYCLES - 1);
    localparam logic [31:0] c_score_max    = 32'd9999;
    localparam logic [7:0]  c_rounds       = 8'(ROUNDS);

    logic [2:0]             r_state;
    logic [2:0]             w_state_nxt;
    logic [31:0]            r_cnt;
    logic [3:0]             r_prev;
    logic [NUM_TARGETS-1:0] r_photo_q;

    logic [3:0]             r_target_idx;
    logic                   r_target_on;
    logic [31:0]            r_score;
    logic [7:0]             r_round_cnt;
    logic                   r_hit_pulse;
    logic                   r_miss_pulse;
    logic                   r_game_over;

    logic                   w_target_on_nxt;
    logic                   w_hit_pulse_nxt;
    logic                   w_miss_pulse_nxt;
    logic                   w_game_over_nxt;

    logic                   w_hit;
    logic                   w_cnt_zero;
    logic [3:0]             w_cand;
    logic [3:0]             w_pick;

    // Only a fresh 0->1 transition on the lit target counts; the edge register
    // runs in every state so a beam already blocked at arming is ignored.
    assign w_hit      = (r_state == S_ARMED) && bus.photo_array[r_target_idx]
                        && !r_photo_q[r_target_idx];
    assign w_cnt_zero = (r_cnt == 32'd0);

    always_comb begin
        w_cand = (bus.rand_num >= c_num_targets) ? (bus.rand_num - c_num_targets)
                                                 : bus.rand_num;
        w_pick = w_cand;
        if (w_cand == r_prev) begin
            w_pick = (w_cand == c_num_targets - 4'd1) ? 4'd0 : (w_cand + 4'd1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_OVER: if (bus.start) w_state_nxt = S_SELECT;
            S_SELECT:       w_state_nxt = S_ARMED;
            S_ARMED: begin
                if (w_hit)           w_state_nxt = S_HIT;
                else if (w_cnt_zero) w_state_nxt = S_MISS;
            end
            S_HIT, S_MISS:  w_state_nxt = S_GAP;
            S_GAP: begin
                if (w_cnt_zero) w_state_nxt = (r_round_cnt == c_rounds) ? S_OVER : S_SELECT;
            end
            default:        w_state_nxt = S_IDLE;
        endcase
    end

    // Status outputs are decoded from the upcoming state and then registered.
    always_comb begin
        w_target_on_nxt  = (w_state_nxt == S_ARMED);
        w_hit_pulse_nxt  = (w_state_nxt == S_HIT);
        w_miss_pulse_nxt = (w_state_nxt == S_MISS);
        w_game_over_nxt  = (w_state_nxt == S_OVER);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_cnt        <= 32'd0;
            r_prev       <= c_no_prev;
            r_photo_q    <= '0;
            r_target_idx <= 4'd0;
            r_target_on  <= 1'b0;
            r_score      <= 32'd0;
            r_round_cnt  <= 8'd0;
            r_hit_pulse  <= 1'b0;
            r_miss_pulse <= 1'b0;
            r_game_over  <= 1'b0;
        end else begin
            r_photo_q    <= bus.photo_array;
            r_target_on  <= w_target_on_nxt;
            r_hit_pulse  <= w_hit_pulse_nxt;
            r_miss_pulse <= w_miss_pulse_nxt;
            r_game_over  <= w_game_over_nxt;
            case (r_state)
                S_IDLE, S_OVER: begin
                    if (bus.start) begin
                        r_score     <= 32'd0;
                        r_round_cnt <= 8'd0;
                        r_prev      <= c_no_prev;
                    end
                end
                S_SELECT: begin
                    r_target_idx <= w_pick;
                    r_cnt        <= c_timeout_load;
                end
                S_ARMED: begin
                    if (!w_hit && !w_cnt_zero) r_cnt <= r_cnt - 32'd1;
                end
                S_HIT: begin
                    if (r_score < c_score_max) r_score <= r_score + 32'd1;
                    r_round_cnt <= r_round_cnt + 8'd1;
                    r_prev      <= r_target_idx;
                    r_cnt       <= c_gap_load;
                end
                S_MISS: begin
                    r_round_cnt <= r_round_cnt + 8'd1;
                    r_prev      <= r_target_idx;
                    r_cnt       <= c_gap_load;
                end
                S_GAP: begin
                    if (!w_cnt_zero) r_cnt <= r_cnt - 32'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.target_idx = r_target_idx;
    assign bus.target_on  = r_target_on;
    assign bus.score      = r_score;
    assign bus.round_cnt  = r_round_cnt;
    assign bus.hit_pulse  = r_hit_pulse;
    assign bus.miss_pulse = r_miss_pulse;
    assign bus.game_over  = r_game_over;

endmodule
`default_nettype wire

// File: doc/target_round_ctrl.md
TARGET_ROUND_CTRL -- requirements
Module: target_round_ctrl

Interface
REQ-001 Parameter NUM_TARGETS, 10, number of photo targets (photo_array width).
REQ-002 Parameter ROUNDS, 20, rounds per game.
REQ-003 Parameter TIMEOUT_CYCLES, 50000000, cycles a target stays armed before a miss.
REQ-004 Parameter GAP_CYCLES, 25000000, idle cycles between rounds.
REQ-005 clock  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-low reset, sampled on the clock rising edge.
REQ-007 start  input  1  request to begin a game; honoured only in IDLE or OVER.
REQ-008 rand_num  input  4  random value from the RNG, sampled in SELECT.
REQ-009 photo_array  input  NUM_TARGETS  photo sensor levels, already synchronised to clock; 1 = beam hit.
REQ-010 target_idx  output  4  index of the current target, 0..NUM_TARGETS-1.
REQ-011 target_on  output  1  target lamp enable; high only in ARMED.
REQ-012 score  output  32  hit count for the current game.
REQ-013 round_cnt  output  8  completed rounds in the current game.
REQ-014 hit_pulse  output  1  one-cycle strobe on a registered hit.
REQ-015 miss_pulse  output  1  one-cycle strobe on a timeout.
REQ-016 game_over  output  1  high while in OVER.

Function
REQ-017 States SHALL be IDLE, SELECT, ARMED, HIT, MISS, GAP and OVER, one-hot or binary encoded.
REQ-018 IDLE/OVER with start=1 -> SELECT next cycle, clearing score, round_cnt, and the previous-target register to 4'hF.
REQ-019 SELECT lasts exactly one cycle: cand = rand_num - NUM_TARGETS if rand_num >= NUM_TARGETS, else rand_num.
REQ-020 If cand equals the previous target, target_idx SHALL be cand+1, wrapping NUM_TARGETS-1 to 0; otherwise target_idx = cand.
REQ-021 SELECT -> ARMED; on ARMED entry the timeout counter loads TIMEOUT_CYCLES-1 and target_on rises that same cycle.
REQ-022 Hit = rising edge (prev 0, now 1) of photo_array[target_idx] while in ARMED; edges on other bits are ignored.
REQ-023 The edge-detect register SHALL update every cycle in every state, so a beam already high at ARMED entry is not a hit.
REQ-024 Hit in ARMED -> HIT next cycle; in HIT: hit_pulse=1, score increments once, target_on=0.
REQ-025 Counter reaching 0 in ARMED with no hit -> MISS; in MISS: miss_pulse=1, score unchanged.
REQ-026 If a hit and counter==0 coincide, hit SHALL take priority.
REQ-027 HIT/MISS last one cycle each, increment round_cnt, record target_idx as the previous target, then -> GAP.
REQ-028 GAP holds for GAP_CYCLES cycles, then -> OVER if round_cnt==ROUNDS, else -> SELECT.
REQ-029 score SHALL saturate at 9999 (4-digit display limit); further hits still pulse hit_pulse.
REQ-030 start outside IDLE/OVER SHALL be ignored.
REQ-031 OVER holds score and round_cnt stable, game_over=1, until start.
REQ-032 hit_pulse and miss_pulse SHALL never be high in the same cycle.
REQ-033 target_idx SHALL hold its value through HIT, MISS and GAP.

Reset
REQ-034 On a rising edge with reset=0: state=IDLE, target_idx=0, target_on=0, score=0, round_cnt=0, hit_pulse=0, miss_pulse=0, game_over=0, counters=0, edge register=0, previous target=4'hF.
REQ-035 Reset asserted mid-game (any state) SHALL take effect on that edge and override start, hits and timeouts.
REQ-036 Outputs SHALL be registered; no output depends combinationally on inputs.

Verification (TIMEOUT_CYCLES=8, GAP_CYCLES=4, ROUNDS=3)
REQ-037 Start, rand_num=3, photo_array[3] rises 2 cycles after target_on -> target_idx=3; hit_pulse 1 cycle later; score=1; round_cnt=1.
REQ-038 rand_num=12, no photo activity -> target_idx=2; target_on high 8 cycles; miss_pulse; score=0.
REQ-039 Prior target 9, rand_num=9 -> target_idx=0; photo_array[5] edge in ARMED -> no hit, MISS after timeout.
REQ-040 photo_array[target_idx] held high before ARMED entry -> no hit; a fall then rise inside the window -> hit.
REQ-041 Hit edge on the counter==0 cycle -> HIT, not MISS; after 3 rounds -> game_over=1, score held; start -> score=0, SELECT.
REQ-042 reset=0 for one cycle during ARMED -> next cycle all outputs at reset values; start required to resume.
